tl_phase_scheduler: RTL and testbench

Phase sequencer for the main-road/side-road intersection. It generates the 1 s timebase, runs the phase state machine and produces the lamp vectors and the remaining-seconds count. The count drives the existing 7-segment digit decode. The block arbitrates the green between main-road traffic, side-road demand (car sensor plus latched pedestrian request) and an emergency preempt that forces main-road green.

---
 rtl/tl_phase_scheduler_if.sv | 15 +
 rtl/tl_phase_scheduler.sv | 137 +++++++++++++
 tb/tb_tl_phase_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tl_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its surroundings:
// raw sensor/request inputs in, lamp vectors, seconds count and tick strobe out.
interface tl_phase_scheduler_if;
  logic       S;
  logic       PED;
  logic       EMRG;
  logic [2:0] MLED;
  logic [2:0] CLED;
  logic [7:0] Num;
  logic       WALK;
  logic       TICK;

  modport master (output S, PED, EMRG, input MLED, CLED, Num, WALK, TICK);
  modport slave  (input S, PED, EMRG, output MLED, CLED, Num, WALK, TICK);
endinterface

// File: rtl/tl_phase_scheduler.sv
// Main/side road phase sequencer: 1 s timebase, phase FSM with side demand,
// latched pedestrian request and emergency preempt, registered lamp/count outputs.
module tl_phase_scheduler #(
  parameter int TICK_DIV = 50000000,
  parameter int G_MAIN   = 60,
  parameter int G_SIDE   = 20,
  parameter int Y_TIME   = 4,
  parameter int R_CLR    = 2
) (
  input logic                CLK,
  input logic                RST,
  tl_phase_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {MG, MY, AR1, SG, SY, AR2} state_t;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       sync_p0, sync_p1;
  logic             s_q, p_q, e_q;
  logic             ped_lat, ped_srv, side_dem, enter_sg;
  state_t           state, state_nx;
  logic [7:0]       num, num_nx;
  logic [2:0]       mled, cled;
  logic             walk;

  function automatic logic [6:0] lamps(state_t st);
    logic [6:0] v;
    v = {3'b100, 3'b100, 1'b0};
    case (st)
      MG:      v = {3'b001, 3'b100, 1'b0};
      MY:      v = {3'b010, 3'b100, 1'b0};
      SG:      v = {3'b100, 3'b001, 1'b1};
      SY:      v = {3'b100, 3'b010, 1'b0};
      default: v = {3'b100, 3'b100, 1'b0};
    endcase
    return v;
  endfunction

  // Timebase: wraps at TICK_DIV-1; that cycle is the only one where phases advance
  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Two-flop synchronizers for {EMRG, PED, S}
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {bus.EMRG, bus.PED, bus.S};
      sync_p1 <= sync_p0;
    end
  end

  assign s_q      = sync_p1[0];
  assign p_q      = sync_p1[1];
  assign e_q      = sync_p1[2];
  assign side_dem = s_q | ped_lat;
  assign enter_sg = (state_nx == SG) && (state != SG);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= MG;
      num   <= 8'(G_MAIN);
      mled  <= 3'b001;
      cled  <= 3'b100;
      walk  <= 1'b0;
    end else begin
      state <= state_nx;
      num   <= num_nx;
      {mled, cled, walk} <= lamps(state_nx);
    end
  end

  // A pedestrian request consumed on SG entry keeps SG alive for its full walk time
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ped_lat <= 1'b0;
      ped_srv <= 1'b0;
    end else begin
      if (enter_sg)  ped_lat <= 1'b0;
      else if (p_q)  ped_lat <= 1'b1;
      if (enter_sg)              ped_srv <= ped_lat | p_q;
      else if (state_nx != SG)   ped_srv <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    num_nx   = num;
    case (state)
      MG: if (tick && !e_q) begin
        if (num != 8'd0)    num_nx = num - 8'd1;
        else if (side_dem) begin state_nx = MY; num_nx = 8'(Y_TIME); end
        else                num_nx = 8'(G_MAIN);
      end
      MY: if (tick) begin
        if (num != 8'd0) num_nx = num - 8'd1;
        else begin state_nx = AR1; num_nx = 8'(R_CLR); end
      end
      AR1: if (tick) begin
        if (num != 8'd0) num_nx = num - 8'd1;
        else if (e_q)    begin state_nx = MG; num_nx = 8'(G_MAIN); end
        else             begin state_nx = SG; num_nx = 8'(G_SIDE); end
      end
      SG: if (tick) begin
        if (e_q || (!s_q && !ped_lat && !ped_srv) || num == 8'd0) begin
          state_nx = SY;
          num_nx   = 8'(Y_TIME);
        end else num_nx = num - 8'd1;
      end
      SY: if (tick) begin
        if (num != 8'd0) num_nx = num - 8'd1;
        else begin state_nx = AR2; num_nx = 8'(R_CLR); end
      end
      AR2: if (tick) begin
        if (num != 8'd0) num_nx = num - 8'd1;
        else begin state_nx = MG; num_nx = 8'(G_MAIN); end
      end
      default: begin
        state_nx = MG;
        num_nx   = 8'(G_MAIN);
      end
    endcase
  end

  assign bus.MLED = mled;
  assign bus.CLED = cled;
  assign bus.Num  = num;
  assign bus.WALK = walk;
  assign bus.TICK = tick;
endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Scoreboard bench for tl_phase_scheduler: directed scenarios push the expected
// post-tick lamp/count state; a monitor pops and compares after every TICK.
module tb_tl_phase_scheduler;
  logic CLK = 1'b0;
  logic RST = 1'b0;

  tl_phase_scheduler_if bus();

  tl_phase_scheduler #(
    .TICK_DIV(4), .G_MAIN(5), .G_SIDE(3), .Y_TIME(1), .R_CLR(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef enum {P_MG, P_MY, P_AR, P_SG, P_SY} ph_t;
  typedef struct packed {
    logic [2:0] m;
    logic [2:0] c;
    logic [7:0] n;
    logic       w;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total = 0;
  int   inv_bad = 0;
  int   tick_bad = 0;
  int   nticks = 0;

  function automatic exp_t mk(ph_t p, int n);
    exp_t e;
    e.n = 8'(n);
    e.w = 1'b0;
    case (p)
      P_MG:    begin e.m = 3'b001; e.c = 3'b100; end
      P_MY:    begin e.m = 3'b010; e.c = 3'b100; end
      P_AR:    begin e.m = 3'b100; e.c = 3'b100; end
      P_SG:    begin e.m = 3'b100; e.c = 3'b001; e.w = 1'b1; end
      default: begin e.m = 3'b100; e.c = 3'b010; end
    endcase
    return e;
  endfunction

  task automatic push(ph_t p, int n);
    q.push_back(mk(p, n));
  endtask

  task automatic push_mg(int from, int to);
    for (int i = from; i >= to; i--) push(P_MG, i);
  endtask

  task automatic push_my_ar1();
    push(P_MY, 1); push(P_MY, 0); push(P_AR, 1); push(P_AR, 0);
  endtask

  task automatic push_sy_ar2();
    push(P_SY, 1); push(P_SY, 0); push(P_AR, 1); push(P_AR, 0);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Wait for n ticks (each bounded), then park just after the following falling edge
  task automatic run(int n);
    int  c;
    bit  got;
    for (int k = 0; k < n; k++) begin
      c = 0;
      got = 1'b0;
      while (!got && c < 16) begin
        @(posedge CLK);
        c++;
        got = RST && bus.TICK;
      end
      if (!got) begin
        total++;
        $display("FAIL tick_timeout: no TICK in %0d CLK, expected one within 4", c);
      end
    end
    @(negedge CLK);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge CLK iff (RST && bus.TICK));
      @(negedge CLK);
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_tick: MLED=%b CLED=%b Num=%0d, expected no tick", bus.MLED, bus.CLED, bus.Num);
      end else begin
        mon_e = q.pop_front();
        if (bus.MLED == mon_e.m && bus.CLED == mon_e.c && bus.Num == mon_e.n && bus.WALK == mon_e.w)
          passed++;
        else
          $display("FAIL tick_state: got MLED=%b CLED=%b Num=%0d WALK=%b, expected MLED=%b CLED=%b Num=%0d WALK=%b",
                   bus.MLED, bus.CLED, bus.Num, bus.WALK, mon_e.m, mon_e.c, mon_e.n, mon_e.w);
      end
    end
  end

  // Tick period: the tick edge must be the 4th rising edge after the previous one / reset release
  initial begin
    int since;
    since = 0;
    forever begin
      @(posedge CLK);
      if (!RST) since = 0;
      else begin
        since++;
        if (bus.TICK) begin
          nticks++;
          if (since != 4) begin
            tick_bad++;
            $display("FAIL tick_period: got %0d CLK, expected 4", since);
          end
          since = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (bus.MLED != 3'b100 && bus.CLED != 3'b100) begin
        inv_bad++;
        $display("FAIL safety: MLED=%b CLED=%b, expected at least one red", bus.MLED, bus.CLED);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.S = 1'b0; bus.PED = 1'b0; bus.EMRG = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_MLED", bus.MLED, 3'b001);
    chk("reset_CLED", bus.CLED, 3'b100);
    chk("reset_Num",  bus.Num,  5);
    chk("reset_WALK", bus.WALK, 0);
    chk("reset_TICK", bus.TICK, 0);

    // No demand: MG recycles 5..0
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 1; k <= 42; k++) push(P_MG, 5 - (k % 6));
    run(42);

    // Car held: full cycle back to MG
    bus.S = 1'b1;
    push_mg(4, 0); push_my_ar1();
    push(P_SG, 3); push(P_SG, 2); push(P_SG, 1); push(P_SG, 0);
    push_sy_ar2(); push(P_MG, 5);
    run(18);

    // Car leaves during SG: early exit to SY
    push_mg(4, 0); push_my_ar1(); push(P_SG, 3); push(P_SG, 2);
    run(11);
    bus.S = 1'b0;
    push_sy_ar2(); push(P_MG, 5); push_mg(4, 0); push(P_MG, 5);
    run(11);

    // Pedestrian pulse: full SG with WALK, then request consumed
    push_mg(4, 0); push_my_ar1();
    push(P_SG, 3); push(P_SG, 2); push(P_SG, 1); push(P_SG, 0);
    push_sy_ar2(); push(P_MG, 5); push_mg(4, 0); push(P_MG, 5);
    bus.PED = 1'b1;
    repeat (3) @(negedge CLK);
    bus.PED = 1'b0;
    run(24);

    // Emergency in SG: SY, AR2, then MG frozen
    bus.S = 1'b1;
    push_mg(4, 0); push_my_ar1(); push(P_SG, 3);
    run(10);
    bus.EMRG = 1'b1;
    push_sy_ar2(); repeat (4) push(P_MG, 5);
    run(8);
    bus.EMRG = 1'b0;
    push_mg(4, 0); push_my_ar1(); push(P_SG, 3);
    run(10);

    // Reset pulse in SY
    push(P_SG, 2); push(P_SG, 1); push(P_SG, 0); push(P_SY, 1);
    run(4);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mid_MLED", bus.MLED, 3'b001);
    chk("rst_mid_CLED", bus.CLED, 3'b100);
    chk("rst_mid_Num",  bus.Num,  5);
    chk("rst_mid_WALK", bus.WALK, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Emergency during AR1 returns to MG and holds
    push_mg(4, 0); push(P_MY, 1); push(P_MY, 0); push(P_AR, 1);
    run(8);
    bus.EMRG = 1'b1;
    push(P_AR, 0); push(P_MG, 5); push(P_MG, 5);
    run(3);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("scoreboard_drain", q.size(), 0);
    chk("tick_count", nticks, 149);
    chk("tick_period_violations", tick_bad, 0);
    chk("safety_violations", inv_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
